// File: rtl/fft_pkg.sv
// Shared constants and types for the FFT result reader.
//   NFFT_LOG2 : log2 of transform length
//   N         : number of bins
//   XK_W      : signed width of one bin component
//   MAG_W     : unsigned width of re^2 + im^2
package fft_pkg;

    localparam int NFFT_LOG2 = 3;
    localparam int N         = 1 << NFFT_LOG2;
    localparam int XK_W      = 28;
    localparam int MAG_W     = 2 * XK_W + 1;

    localparam logic [NFFT_LOG2-1:0] IDX_ONE  = NFFT_LOG2'(1);
    localparam logic [NFFT_LOG2-1:0] IDX_LAST = NFFT_LOG2'(N - 1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CAPTURE = 2'd1,
        EMIT    = 2'd2
    } state_t;

endpackage

// File: rtl/fft_cmag_sq.sv
// Combinational squared magnitude of a signed complex bin.
//   re, im : signed XK_W-bit components (two's complement)
//   mag    : unsigned MAG_W-bit re^2 + im^2, exact (no truncation/saturation)
module fft_cmag_sq
    import fft_pkg::*;
(
    input  logic [XK_W-1:0]  re,
    input  logic [XK_W-1:0]  im,
    output logic [MAG_W-1:0] mag
);

    logic [2*XK_W-1:0] re_x;
    logic [2*XK_W-1:0] im_x;
    logic [2*XK_W-1:0] re_sq;
    logic [2*XK_W-1:0] im_sq;

    // Sign-extend to the product width; the true square always fits in
    // 2*XK_W bits, so the low half of the wide product is exact.
    assign re_x  = {{XK_W{re[XK_W-1]}}, re};
    assign im_x  = {{XK_W{im[XK_W-1]}}, im};
    assign re_sq = re_x * re_x;
    assign im_sq = im_x * im_x;
    assign mag   = {1'b0, re_sq} + {1'b0, im_sq};

endmodule

// File: rtl/fft_result_reader.sv
// Output-side controller for the 8-point FFT core. Waits for done, pulses
// unload, captures dv beats into a bin buffer by xk_index while tracking the
// peak-magnitude bin, then streams all bins in index order on valid/ready.
//   clk, rst_n                : clock, async active-low reset
//   done / unload             : core complete in, one-cycle unload request out
//   dv, xk_index, xk_re/im    : core result beats
//   m_valid/m_ready, m_index, m_re/im, m_mag, m_last : bin stream
//   frame_done                : pulse after the last transfer
//   peak_index, peak_mag      : peak bin of the last completed frame
//   overrun                   : sticky, done seen outside IDLE
//
// state   | meaning
// --------+-------------------------------------------------
// IDLE    | waiting for done
// CAPTURE | storing dv beats, N beats move on to EMIT
// EMIT    | streaming buf[0..N-1], last transfer returns to IDLE
module fft_result_reader
    import fft_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 done,
    output logic                 unload,
    input  logic                 dv,
    input  logic [NFFT_LOG2-1:0] xk_index,
    input  logic [XK_W-1:0]      xk_re,
    input  logic [XK_W-1:0]      xk_im,
    output logic                 m_valid,
    input  logic                 m_ready,
    output logic [NFFT_LOG2-1:0] m_index,
    output logic [XK_W-1:0]      m_re,
    output logic [XK_W-1:0]      m_im,
    output logic [MAG_W-1:0]     m_mag,
    output logic                 m_last,
    output logic                 frame_done,
    output logic [NFFT_LOG2-1:0] peak_index,
    output logic [MAG_W-1:0]     peak_mag,
    output logic                 overrun
);

    state_t state_q, state_d;

    logic [XK_W-1:0]      buf_re_q [N];
    logic [XK_W-1:0]      buf_re_d [N];
    logic [XK_W-1:0]      buf_im_q [N];
    logic [XK_W-1:0]      buf_im_d [N];
    logic [NFFT_LOG2-1:0] beat_cnt_q, beat_cnt_d;
    logic [NFFT_LOG2-1:0] ptr_q, ptr_d;
    logic [NFFT_LOG2-1:0] run_idx_q, run_idx_d;
    logic [MAG_W-1:0]     run_mag_q, run_mag_d;
    logic [NFFT_LOG2-1:0] peak_index_q, peak_index_d;
    logic [MAG_W-1:0]     peak_mag_q, peak_mag_d;
    logic                 unload_q, unload_d;
    logic                 frame_done_q, frame_done_d;
    logic                 overrun_q, overrun_d;

    logic [MAG_W-1:0]     cap_mag;
    logic [MAG_W-1:0]     rd_mag;
    logic [XK_W-1:0]      rd_re;
    logic [XK_W-1:0]      rd_im;
    logic                 start;
    logic                 beat;
    logic                 xfer;
    logic                 xfer_last;

    assign rd_re     = buf_re_q[ptr_q];
    assign rd_im     = buf_im_q[ptr_q];
    assign start     = (state_q == IDLE) && done;
    assign beat      = (state_q == CAPTURE) && dv;
    assign xfer      = (state_q == EMIT) && m_ready;
    assign xfer_last = xfer && (ptr_q == IDX_LAST);

    fft_cmag_sq u_cmag_cap (
        .re  (xk_re),
        .im  (xk_im),
        .mag (cap_mag)
    );

    fft_cmag_sq u_cmag_rd (
        .re  (rd_re),
        .im  (rd_im),
        .mag (rd_mag)
    );

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (done) state_d = CAPTURE;
            CAPTURE: if (dv && (beat_cnt_q == IDX_LAST)) state_d = EMIT;
            EMIT:    if (m_ready && (ptr_q == IDX_LAST)) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Output logic; bin fields read as zero whenever nothing is offered
    always_comb begin
        m_valid = (state_q == EMIT);
        m_last  = m_valid && (ptr_q == IDX_LAST);
        m_index = m_valid ? ptr_q  : '0;
        m_re    = m_valid ? rd_re  : '0;
        m_im    = m_valid ? rd_im  : '0;
        m_mag   = m_valid ? rd_mag : '0;
    end

    // Datapath next values
    always_comb begin
        buf_re_d     = buf_re_q;
        buf_im_d     = buf_im_q;
        beat_cnt_d   = beat_cnt_q;
        ptr_d        = ptr_q;
        run_idx_d    = run_idx_q;
        run_mag_d    = run_mag_q;
        peak_index_d = peak_index_q;
        peak_mag_d   = peak_mag_q;
        unload_d     = start;
        frame_done_d = xfer_last;
        overrun_d    = overrun_q || (done && (state_q != IDLE));

        if (start) begin
            beat_cnt_d = '0;
            ptr_d      = '0;
            run_idx_d  = '0;
            run_mag_d  = '0;
        end

        if (beat) begin
            buf_re_d[xk_index] = xk_re;
            buf_im_d[xk_index] = xk_im;
            beat_cnt_d         = beat_cnt_q + IDX_ONE;
            // Strictly greater keeps the earlier bin on ties.
            if ((beat_cnt_q == '0) || (cap_mag > run_mag_q)) begin
                run_idx_d = xk_index;
                run_mag_d = cap_mag;
            end
        end

        if (xfer) begin
            ptr_d = ptr_q + IDX_ONE;
        end

        if (xfer_last) begin
            peak_index_d = run_idx_q;
            peak_mag_d   = run_mag_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            buf_re_q     <= '{default: '0};
            buf_im_q     <= '{default: '0};
            beat_cnt_q   <= '0;
            ptr_q        <= '0;
            run_idx_q    <= '0;
            run_mag_q    <= '0;
            peak_index_q <= '0;
            peak_mag_q   <= '0;
            unload_q     <= 1'b0;
            frame_done_q <= 1'b0;
            overrun_q    <= 1'b0;
        end else begin
            buf_re_q     <= buf_re_d;
            buf_im_q     <= buf_im_d;
            beat_cnt_q   <= beat_cnt_d;
            ptr_q        <= ptr_d;
            run_idx_q    <= run_idx_d;
            run_mag_q    <= run_mag_d;
            peak_index_q <= peak_index_d;
            peak_mag_q   <= peak_mag_d;
            unload_q     <= unload_d;
            frame_done_q <= frame_done_d;
            overrun_q    <= overrun_d;
        end
    end

    assign unload     = unload_q;
    assign frame_done = frame_done_q;
    assign peak_index = peak_index_q;
    assign peak_mag   = peak_mag_q;
    assign overrun    = overrun_q;

endmodule
